// File: rtl/mem_access_unit_if.sv
// Request, response and memory-port signals of mem_access_unit.
// The slave modport is the unit's side; the master modport is the requester/memory side.
interface mem_access_unit_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 12
);
  localparam int unsigned BYTES = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              mem_en;
  logic [BYTES-1:0]  mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_store, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_store, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Big-endian load/store unit for a DATA_W (32/64) word memory port.
// Define MEM_ACCESS_MISALIGN_EN to execute word-crossing accesses as two beats.
module mem_access_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 12
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);
  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned LB    = $clog2(BYTES);
  localparam int unsigned NW    = LB + 2;

`ifdef MEM_ACCESS_MISALIGN_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ST2 = 3'd1, S_LD1 = 3'd2, S_LD2 = 3'd3, S_RESP = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LD1 = 3'd2, S_RESP = 3'd4
  } state_t;
`endif

  state_t state_q, state_d;

  // Request decode in the acceptance cycle
  logic [LB-1:0]     req_off;
  logic [NW-1:0]     req_n;
  logic [NW-1:0]     req_end;
  logic              req_split;
  logic              size_bad;
  logic              req_illegal;
  logic [ADDR_W-1:0] req_word;
  logic              accept;

  assign req_off   = bus.req_addr[LB-1:0];
  assign req_n     = NW'(1) << bus.req_size;
  assign req_end   = NW'(req_off) + req_n;
  assign req_split = req_end > NW'(BYTES);
  assign size_bad  = (bus.req_size == 2'd3) && (DATA_W != 64);
  assign req_word  = bus.req_addr[ADDR_W+LB-1:LB];
  assign accept    = (state_q == S_IDLE) && bus.req_valid;

`ifdef MEM_ACCESS_MISALIGN_EN
  assign req_illegal = size_bad;
`else
  assign req_illegal = size_bad || req_split;
`endif

  if (ADDR_W + LB < 32) begin : g_unused
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+LB];
  end

  // Registered request fields
  logic [1:0]        r_size;
  logic              r_signed;
  logic [LB-1:0]     r_off;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
`ifdef MEM_ACCESS_MISALIGN_EN
  logic              r_split;
  logic [DATA_W-1:0] beat0_q;
`endif

  // Store data placed MSB-first from lane off across a two-word window
  function automatic logic [2*DATA_W-1:0] place_data(input logic [DATA_W-1:0] wd,
                                                     input logic [1:0] size,
                                                     input logic [LB-1:0] off);
    logic [DATA_W-1:0] left;
    int unsigned       sh;
    sh   = DATA_W - (32'd8 << size);
    left = wd << sh;
    return {left, {DATA_W{1'b0}}} >> (32'(off) << 3);
  endfunction

  function automatic logic [2*BYTES-1:0] place_mask(input logic [1:0] size,
                                                    input logic [LB-1:0] off);
    logic [BYTES-1:0] left;
    left = ~({BYTES{1'b1}} >> (32'd1 << size));
    return {left, {BYTES{1'b0}}} >> 32'(off);
  endfunction

  // Pick bytes off..off+n-1 of {b0,b1}, right-justify and extend
  function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] b0,
                                                input logic [DATA_W-1:0] b1,
                                                input logic [1:0] size,
                                                input logic [LB-1:0] off,
                                                input logic sgn);
    logic [2*DATA_W-1:0] cat;
    logic [DATA_W-1:0]   top;
    logic [DATA_W-1:0]   res;
    int unsigned         nbits;
    cat   = {b0, b1} << (32'(off) << 3);
    top   = cat[2*DATA_W-1 -: DATA_W];
    nbits = 32'd8 << size;
    res   = top >> (DATA_W - nbits);
    if (sgn && top[DATA_W-1]) res = res | ({DATA_W{1'b1}} << nbits);
    return res;
  endfunction

  logic [DATA_W-1:0]   sel_wdata;
  logic [1:0]          sel_size;
  logic [LB-1:0]       sel_off;
  logic [2*DATA_W-1:0] pdata;
  logic [2*BYTES-1:0]  pmask;

  assign sel_wdata = (state_q == S_IDLE) ? bus.req_wdata : r_wdata;
  assign sel_size  = (state_q == S_IDLE) ? bus.req_size  : r_size;
  assign sel_off   = (state_q == S_IDLE) ? req_off       : r_off;
  assign pdata     = place_data(sel_wdata, sel_size, sel_off);
  assign pmask     = place_mask(sel_size, sel_off);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (req_illegal) begin
            state_d = S_RESP;
          end else if (bus.req_store) begin
`ifdef MEM_ACCESS_MISALIGN_EN
            state_d = req_split ? S_ST2 : S_RESP;
`else
            state_d = S_RESP;
`endif
          end else begin
            state_d = S_LD1;
          end
        end
      end
`ifdef MEM_ACCESS_MISALIGN_EN
      S_ST2:   state_d = S_RESP;
      S_LD1:   state_d = r_split ? S_LD2 : S_RESP;
      S_LD2:   state_d = S_RESP;
`else
      S_LD1:   state_d = S_RESP;
`endif
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: handshake and memory beats
  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid && !req_illegal) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = req_word;
          if (bus.req_store) begin
            bus.mem_we    = pmask[2*BYTES-1 -: BYTES];
            bus.mem_wdata = pdata[2*DATA_W-1 -: DATA_W];
          end
        end
      end
`ifdef MEM_ACCESS_MISALIGN_EN
      S_ST2: begin
        bus.mem_en    = 1'b1;
        bus.mem_addr  = r_addr + ADDR_W'(1);
        bus.mem_we    = pmask[BYTES-1:0];
        bus.mem_wdata = pdata[DATA_W-1:0];
      end
      S_LD1: begin
        if (r_split) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = r_addr + ADDR_W'(1);
        end
      end
`endif
      S_RESP:  bus.rsp_valid = 1'b1;
      default: ;
    endcase
    if (!rst) begin
      bus.mem_en    = 1'b0;
      bus.mem_we    = '0;
      bus.mem_wdata = '0;
    end
  end

  // Request capture, load beat capture and response data
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_size      <= '0;
      r_signed    <= 1'b0;
      r_off       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef MEM_ACCESS_MISALIGN_EN
      r_split     <= 1'b0;
      beat0_q     <= '0;
`endif
    end else begin
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      if (accept) begin
        r_size   <= bus.req_size;
        r_signed <= bus.req_signed;
        r_off    <= req_off;
        r_addr   <= req_word;
        r_wdata  <= bus.req_wdata;
        if (req_illegal) rsp_err_q <= 1'b1;
`ifdef MEM_ACCESS_MISALIGN_EN
        r_split  <= req_split;
`endif
      end
`ifdef MEM_ACCESS_MISALIGN_EN
      if (state_q == S_LD1) begin
        beat0_q <= bus.mem_rdata;
        if (!r_split) rsp_rdata_q <= extract(bus.mem_rdata, '0, r_size, r_off, r_signed);
      end
      if (state_q == S_LD2) begin
        rsp_rdata_q <= extract(beat0_q, bus.mem_rdata, r_size, r_off, r_signed);
      end
`else
      if (state_q == S_LD1) begin
        rsp_rdata_q <= extract(bus.mem_rdata, '0, r_size, r_off, r_signed);
      end
`endif
    end
  end

  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (DATA_W=32); expectations follow MEM_ACCESS_MISALIGN_EN.
module tb_mem_access_unit;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 12;

  logic clk;
  logic rst;

  mem_access_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-only word memory; read data appears the cycle after a read beat
  logic [31:0] tmem [0:4095];
  always @(posedge clk) begin
    if (bus.mem_en === 1'b1 && bus.mem_we == 4'b0000) bus.mem_rdata <= tmem[bus.mem_addr];
  end

  // Beat log
  logic [11:0] b_addr[$];
  logic [3:0]  b_we[$];
  logic [31:0] b_wd[$];
  always @(negedge clk) begin
    if (bus.mem_en === 1'b1) begin
      b_addr.push_back(bus.mem_addr);
      b_we.push_back(bus.mem_we);
      b_wd.push_back(bus.mem_wdata);
    end
  end

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] ad;
    logic [31:0] wd;
    int          lat;
    logic        err;
    logic [31:0] rd;
    int          nb;
    logic [11:0] a0;
    logic [3:0]  we0;
    logic [31:0] wd0;
    logic [11:0] a1;
    logic [3:0]  we1;
    logic [31:0] wd1;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic st, logic [1:0] sz, logic sg, logic [31:0] ad, logic [31:0] wd,
                              int lat, logic err, logic [31:0] rd, int nb,
                              logic [11:0] a0, logic [3:0] we0, logic [31:0] wd0,
                              logic [11:0] a1, logic [3:0] we1, logic [31:0] wd1);
    vec_t v;
    v.st = st; v.sz = sz; v.sg = sg; v.ad = ad; v.wd = wd;
    v.lat = lat; v.err = err; v.rd = rd; v.nb = nb;
    v.a0 = a0; v.we0 = we0; v.wd0 = wd0; v.a1 = a1; v.we1 = we1; v.wd1 = wd1;
    return v;
  endfunction

  function automatic vec_t mk_err(logic st, logic [1:0] sz, logic [31:0] ad, logic [31:0] wd);
    return mk(st, sz, 1'b0, ad, wd, 1, 1'b1, 32'h0, 0, 12'h0, 4'h0, 32'h0, 12'h0, 4'h0, 32'h0);
  endfunction

  function automatic logic [31:0] lanes(input logic [31:0] wd, input logic [3:0] we);
    return wd & {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
  endfunction

  task automatic drive(input vec_t v);
    bus.req_valid  = 1'b1;
    bus.req_store  = v.st;
    bus.req_size   = v.sz;
    bus.req_signed = v.sg;
    bus.req_addr   = v.ad;
    bus.req_wdata  = v.wd;
  endtask

  // Entered and left #1 after a rising edge with the unit idle
  task automatic run_vec(input int idx, input vec_t v);
    int          lat;
    logic        err;
    logic [31:0] rd;
    b_addr.delete(); b_we.delete(); b_wd.delete();
    drive(v);
    @(negedge clk);
    check($sformatf("v%0d ready", idx), 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0; err = 1'b0; rd = 32'h0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        lat = c; err = bus.rsp_err; rd = bus.rsp_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat != 0) begin
      @(posedge clk); #1;
    end
    check($sformatf("v%0d latency", idx), 64'(lat), 64'(v.lat));
    check($sformatf("v%0d rsp_err", idx), 64'(err), 64'(v.err));
    check($sformatf("v%0d rsp_rdata", idx), 64'(rd), 64'(v.rd));
    check($sformatf("v%0d beats", idx), 64'(b_addr.size()), 64'(v.nb));
    if (b_addr.size() > 0 && v.nb > 0) begin
      check($sformatf("v%0d b0 addr", idx), 64'(b_addr[0]), 64'(v.a0));
      check($sformatf("v%0d b0 we", idx), 64'(b_we[0]), 64'(v.we0));
      check($sformatf("v%0d b0 wdata", idx), 64'(lanes(b_wd[0], b_we[0])), 64'(v.wd0));
    end
    if (b_addr.size() > 1 && v.nb > 1) begin
      check($sformatf("v%0d b1 addr", idx), 64'(b_addr[1]), 64'(v.a1));
      check($sformatf("v%0d b1 we", idx), 64'(b_we[1]), 64'(v.we1));
      check($sformatf("v%0d b1 wdata", idx), 64'(lanes(b_wd[1], b_we[1])), 64'(v.wd1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    vec_t mid;
    int   rsp_seen;

    for (int i = 0; i < 4096; i++) tmem[i] = 32'h0;
    tmem[0]     = 32'h01020304;
    tmem[4]     = 32'hA0A1A2A3;
    tmem[5]     = 32'h11223344;
    tmem[6]     = 32'h55667788;
    tmem[8]     = 32'h112233F4;
    tmem[9]     = 32'h80817F00;
    tmem[12'hFFF] = 32'hCAFEBABE;

    // Aligned accesses
    vecs.push_back(mk(0, 2'd2, 0, 32'h14, 0, 2, 0, 32'h11223344, 1, 12'd5, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'd0, 1, 32'h23, 0, 2, 0, 32'hFFFFFFF4, 1, 12'd8, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'd0, 0, 32'h23, 0, 2, 0, 32'h000000F4, 1, 12'd8, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'd1, 1, 32'h24, 0, 2, 0, 32'hFFFF8081, 1, 12'd9, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'd1, 0, 32'h24, 0, 2, 0, 32'h00008081, 1, 12'd9, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'd0, 1, 32'h26, 0, 2, 0, 32'h0000007F, 1, 12'd9, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'd2, 1, 32'h24, 0, 2, 0, 32'h80817F00, 1, 12'd9, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2'd0, 0, 32'h15, 32'h000000AB, 1, 0, 0, 1, 12'd5, 4'b0100, 32'h00AB0000, 0, 0, 0));
    vecs.push_back(mk(1, 2'd1, 0, 32'h16, 32'h1234ABCD, 1, 0, 0, 1, 12'd5, 4'b0011, 32'h0000ABCD, 0, 0, 0));
    vecs.push_back(mk(1, 2'd2, 0, 32'h18, 32'hDEADBEEF, 1, 0, 0, 1, 12'd6, 4'b1111, 32'hDEADBEEF, 0, 0, 0));
    // Doubleword on a 32-bit port is always rejected
    vecs.push_back(mk_err(0, 2'd3, 32'h10, 0));
    vecs.push_back(mk_err(1, 2'd3, 32'h14, 32'h12345678));
    // Word-crossing accesses
`ifdef MEM_ACCESS_MISALIGN_EN
    vecs.push_back(mk(0, 2'd2, 0, 32'h16, 0, 3, 0, 32'h33445566, 2, 12'd5, 4'h0, 0, 12'd6, 4'h0, 0));
    vecs.push_back(mk(1, 2'd1, 0, 32'h17, 32'h0000ABCD, 2, 0, 0, 2,
                      12'd5, 4'b0001, 32'h000000AB, 12'd6, 4'b1000, 32'hCD000000));
    vecs.push_back(mk(1, 2'd1, 0, 32'h3FFF, 32'h0000ABCD, 2, 0, 0, 2,
                      12'hFFF, 4'b0001, 32'h000000AB, 12'h000, 4'b1000, 32'hCD000000));
    vecs.push_back(mk(1, 2'd2, 0, 32'h19, 32'h11223344, 2, 0, 0, 2,
                      12'd6, 4'b0111, 32'h00112233, 12'd7, 4'b1000, 32'h44000000));
    vecs.push_back(mk(0, 2'd1, 0, 32'h13, 0, 3, 0, 32'h0000A311, 2, 12'd4, 4'h0, 0, 12'd5, 4'h0, 0));
    vecs.push_back(mk(0, 2'd2, 1, 32'h3FFE, 0, 3, 0, 32'hBABE0102, 2, 12'hFFF, 4'h0, 0, 12'h000, 4'h0, 0));
`else
    vecs.push_back(mk_err(0, 2'd2, 32'h16, 0));
    vecs.push_back(mk_err(1, 2'd1, 32'h17, 32'h0000ABCD));
    vecs.push_back(mk_err(1, 2'd1, 32'h3FFF, 32'h0000ABCD));
    vecs.push_back(mk_err(1, 2'd2, 32'h19, 32'h11223344));
    vecs.push_back(mk_err(0, 2'd1, 32'h13, 0));
    vecs.push_back(mk_err(0, 2'd2, 32'h3FFE, 0));
`endif

    // Reset, with a request presented while held in reset
    rst = 1'b0;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    drive(vecs[0]);
    @(negedge clk);
    check("reset mem_en", 64'(bus.mem_en), 64'd0);
    check("reset mem_we", 64'(bus.mem_we), 64'd0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("idle req_ready", 64'(bus.req_ready), 64'd1);
    check("idle rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("idle rsp_err", 64'(bus.rsp_err), 64'd0);
    check("idle rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check("idle mem_en", 64'(bus.mem_en), 64'd0);
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset in the cycle after acceptance abandons the request
`ifdef MEM_ACCESS_MISALIGN_EN
    mid = vecs[13];
`else
    mid = vecs[0];
`endif
    b_addr.delete(); b_we.delete(); b_wd.delete();
    drive(mid);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("midrst mem_en", 64'(bus.mem_en), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst req_ready", 64'(bus.req_ready), 64'd1);
    rsp_seen = 0;
    repeat (4) begin
      if (bus.rsp_valid === 1'b1) rsp_seen++;
      @(posedge clk);
      @(negedge clk);
    end
    check("midrst rsp_valid count", 64'(rsp_seen), 64'd0);
    check("midrst beats", 64'(b_addr.size()), 64'd1);
    @(posedge clk); #1;

    // Unit recovers after the abandoned request
    run_vec(100, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
